pipeline_lsu: RTL

- Parametrised load/store unit that replaces the single-cycle MEM-stage memory path in the pipeline.
- Accepts one load/store per handshake from EXE and drives a req/gnt/rvalid data-memory port that tolerates variable latency.
- Stalls EXE while a transaction is outstanding and traps misaligned accesses instead of silently merging them.
- Detects bus timeout, then returns formatted load data plus status to WB.

---
 rtl/pipeline_lsu_pkg.sv | 42 ++++
 rtl/pipeline_lsu_if.sv | 53 +++++
 rtl/pipeline_lsu_align.sv | 80 ++++++++
 rtl/pipeline_lsu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_lsu_pkg
//  Description : Shared memory-op codes, LSU state encoding and op helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_lsu_pkg;

    typedef enum logic [3:0] {
        DMEM_NO  = 4'd0,
        DMEM_LB  = 4'd1,
        DMEM_LH  = 4'd2,
        DMEM_LW  = 4'd3,
        DMEM_LBU = 4'd4,
        DMEM_LHU = 4'd5,
        DMEM_SB  = 4'd6,
        DMEM_SH  = 4'd7,
        DMEM_SW  = 4'd8
    } dmem_type_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [3:0] t);
        return (t == DMEM_LB) || (t == DMEM_LH) || (t == DMEM_LW) ||
               (t == DMEM_LBU) || (t == DMEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] t);
        return (t == DMEM_SB) || (t == DMEM_SH) || (t == DMEM_SW);
    endfunction

    // Codes outside the load/store set are handled exactly like DMEM_NO
    function automatic logic is_mem_op(input logic [3:0] t);
        return is_load(t) || is_store(t);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_lsu_if
//  Description : EXE request, data-memory port and WB result bundle of the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_lsu_if #(
    parameter int DMEM_AW = 10,
    parameter int TAG_W   = 48
);
    // EXE side
    logic               ex_valid_i;
    logic               ex_ready_o;
    logic [3:0]         dmem_type_i;
    logic [31:0]        addr_i;
    logic [31:0]        wdata_i;
    logic [TAG_W-1:0]   tag_i;
    // data-memory port
    logic               dmem_req_o;
    logic               dmem_we_o;
    logic [DMEM_AW-1:0] dmem_addr_o;
    logic [3:0]         dmem_be_o;
    logic [31:0]        dmem_wdata_o;
    logic               dmem_gnt_i;
    logic               dmem_rvalid_i;
    logic [31:0]        dmem_rdata_i;
    // WB side
    logic               wb_valid_o;
    logic [31:0]        wb_rdata_o;
    logic [TAG_W-1:0]   wb_tag_o;
    logic [31:0]        wb_addr_o;
    logic               wb_misaligned_o;
    logic               wb_bus_err_o;

    // LSU view
    modport slave (
        input  ex_valid_i, dmem_type_i, addr_i, wdata_i, tag_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output ex_ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
               dmem_wdata_o, wb_valid_o, wb_rdata_o, wb_tag_o, wb_addr_o,
               wb_misaligned_o, wb_bus_err_o
    );

    // Pipeline / memory environment view
    modport master (
        output ex_valid_i, dmem_type_i, addr_i, wdata_i, tag_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  ex_ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
               dmem_wdata_o, wb_valid_o, wb_rdata_o, wb_tag_o, wb_addr_o,
               wb_misaligned_o, wb_bus_err_o
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_lsu_align
//  Description : Byte-lane steering for stores, load extract/extend and
//                misalignment detection (purely combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_lsu_align
    import pipeline_lsu_pkg::*;
(
    input  logic [3:0]  i_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [31:0] w_rshift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction from the read word
    always_comb begin
        w_rshift = i_rdata >> {i_addr_lo, 3'b000};
        w_byte   = w_rshift[7:0];
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Byte enables (loads and stores) and lane-aligned store data
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        case (i_type)
            DMEM_LB, DMEM_LBU: o_be = 4'b0001 << i_addr_lo;
            DMEM_LH, DMEM_LHU: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            DMEM_LW:           o_be = 4'b1111;
            DMEM_SB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {24'h0, i_wdata[7:0]} << {i_addr_lo, 3'b000};
            end
            DMEM_SH: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = i_addr_lo[1] ? {i_wdata[15:0], 16'h0} : {16'h0, i_wdata[15:0]};
            end
            DMEM_SW: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: ;
        endcase
    end

    // Load data formatting with sign/zero extension
    always_comb begin
        o_rdata = 32'h0;
        case (i_type)
            DMEM_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            DMEM_LBU: o_rdata = {24'h0, w_byte};
            DMEM_LH:  o_rdata = {{16{w_half[15]}}, w_half};
            DMEM_LHU: o_rdata = {16'h0, w_half};
            DMEM_LW:  o_rdata = i_rdata;
            default:  ;
        endcase
    end

    // Halfword needs bit 0 clear, word needs bits 1:0 clear
    always_comb begin
        o_misaligned = 1'b0;
        case (i_type)
            DMEM_LH, DMEM_LHU, DMEM_SH: o_misaligned = i_addr_lo[0];
            DMEM_LW, DMEM_SW:           o_misaligned = |i_addr_lo;
            default:                    ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_lsu
//  Description : Load/store unit with req/gnt/rvalid memory port, EXE stall,
//                misalignment trap and bus timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_lsu
    import pipeline_lsu_pkg::*;
#(
    parameter int          DMEM_AW = 10,
    parameter int          TAG_W   = 48,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_lsu_if.slave  lsu
);

    localparam int                 c_CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = TIMEOUT[c_CNT_W-1:0];
    localparam bit                 c_TIMEOUT_EN = (TIMEOUT != 0);

    lsu_state_e         r_state;
    lsu_state_e         w_state_nxt;
    logic [3:0]         r_type;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [TAG_W-1:0]   r_tag;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic               r_wb_valid;
    logic [31:0]        r_wb_rdata;
    logic [TAG_W-1:0]   r_wb_tag;
    logic [31:0]        r_wb_addr;
    logic               r_wb_mis;
    logic               r_wb_err;

    logic               w_idle;
    logic               w_req;
    logic               w_accept;
    logic               w_is_load;
    logic               w_timeout;
    logic [3:0]         w_al_type;
    logic [1:0]         w_al_addr_lo;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_lane;
    logic [31:0]        w_rdata_fmt;
    logic               w_misaligned;

    // completion decode: done this cycle, with load data / trap flavour,
    // and whether tag/addr come straight from the EXE inputs
    logic               w_done;
    logic               w_done_ld;
    logic               w_done_mis;
    logic               w_done_err;
    logic               w_done_new;

    assign w_idle    = (r_state == LSU_IDLE);
    assign w_req     = (r_state == LSU_REQ);
    assign w_accept  = lsu.ex_valid_i & w_idle;
    assign w_is_load = is_load(r_type);
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_timeout = c_TIMEOUT_EN && (w_cnt_nxt == c_TIMEOUT);

    // In IDLE the aligner inspects the incoming op (trap check); otherwise
    // it works on the captured op (lanes, load formatting)
    assign w_al_type    = w_idle ? lsu.dmem_type_i : r_type;
    assign w_al_addr_lo = w_idle ? lsu.addr_i[1:0] : r_addr[1:0];

    pipeline_lsu_align u_align (
        .i_type       (w_al_type),
        .i_addr_lo    (w_al_addr_lo),
        .i_wdata      (r_wdata),
        .i_rdata      (lsu.dmem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata_lane),
        .o_rdata      (w_rdata_fmt),
        .o_misaligned (w_misaligned)
    );

    assign lsu.ex_ready_o      = w_idle;
    assign lsu.dmem_req_o      = w_req;
    assign lsu.dmem_we_o       = w_req & ~w_is_load;
    assign lsu.dmem_addr_o     = w_req ? r_addr[DMEM_AW+1:2] : '0;
    assign lsu.dmem_be_o       = w_req ? w_be : 4'b0000;
    assign lsu.dmem_wdata_o    = w_req ? w_wdata_lane : 32'h0;
    assign lsu.wb_valid_o      = r_wb_valid;
    assign lsu.wb_rdata_o      = r_wb_rdata;
    assign lsu.wb_tag_o        = r_wb_tag;
    assign lsu.wb_addr_o       = r_wb_addr;
    assign lsu.wb_misaligned_o = r_wb_mis;
    assign lsu.wb_bus_err_o    = r_wb_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= LSU_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_done_ld   = 1'b0;
        w_done_mis  = 1'b0;
        w_done_err  = 1'b0;
        w_done_new  = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept) begin
                    if (!is_mem_op(lsu.dmem_type_i)) begin
                        w_done     = 1'b1;
                        w_done_new = 1'b1;
                    end else if (w_misaligned) begin
                        w_done     = 1'b1;
                        w_done_new = 1'b1;
                        w_done_mis = 1'b1;
                    end else begin
                        w_state_nxt = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (lsu.dmem_gnt_i) begin
                    if (!w_is_load) begin
                        w_done      = 1'b1;
                        w_state_nxt = LSU_IDLE;
                    end else if (lsu.dmem_rvalid_i) begin
                        w_done      = 1'b1;
                        w_done_ld   = 1'b1;
                        w_state_nxt = LSU_IDLE;
                    end else begin
                        w_state_nxt = LSU_RESP;
                    end
                end else if (w_timeout) begin
                    w_done      = 1'b1;
                    w_done_err  = 1'b1;
                    w_state_nxt = LSU_IDLE;
                end
            end
            LSU_RESP: begin
                if (lsu.dmem_rvalid_i) begin
                    w_done      = 1'b1;
                    w_done_ld   = 1'b1;
                    w_state_nxt = LSU_IDLE;
                end else if (w_timeout) begin
                    w_done      = 1'b1;
                    w_done_err  = 1'b1;
                    w_state_nxt = LSU_IDLE;
                end
            end
            default: w_state_nxt = LSU_IDLE;
        endcase
    end

    // Capture the EXE op on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_type  <= 4'h0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_tag   <= '0;
        end else if (w_accept) begin
            r_type  <= lsu.dmem_type_i;
            r_addr  <= lsu.addr_i;
            r_wdata <= lsu.wdata_i;
            r_tag   <= lsu.tag_i;
        end
    end

    // Bus wait counter: cleared on accept, counts REQ/RESP cycles
    always_ff @(posedge clk) begin
        if (reset)                   r_cnt <= '0;
        else if (w_accept)           r_cnt <= '0;
        else if (r_state != LSU_IDLE) r_cnt <= w_cnt_nxt;
    end

    // WB result registers; fields hold between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rdata <= 32'h0;
            r_wb_tag   <= '0;
            r_wb_addr  <= 32'h0;
            r_wb_mis   <= 1'b0;
            r_wb_err   <= 1'b0;
        end else begin
            r_wb_valid <= w_done;
            if (w_done) begin
                r_wb_rdata <= w_done_ld ? w_rdata_fmt : 32'h0;
                r_wb_tag   <= w_done_new ? lsu.tag_i : r_tag;
                r_wb_addr  <= w_done_new ? lsu.addr_i : r_addr;
                r_wb_mis   <= w_done_mis;
                r_wb_err   <= w_done_err;
            end
        end
    end

endmodule
`default_nettype wire
